led_decoder_seq: RTL and testbench
==================================

Name: led_decoder_seq

Overview:
- Parametrised, registered N-to-2^N decoder driving active-low LEDs.
- Successor to the fixed 3-to-8 gated decoder: generalised select width and gate code.
- Adds sequential modes: auto-chase (running light) and blink of the selected LED, both paced by an internal prescaler.
- Sits between board switch/enable inputs and the LED bank.

Parameters:
- SEL_W, 3, select width; LED_N = 2**SEL_W is derived as a localparam, not overridable.
- EN_W, 3, width of the enable/gate input.
- ENABLE_CODE, 3'b100, enable value that opens the gate (G1=1, G2A=0, G2B=0 style).
- PRESCALE, 4, clk cycles per step tick; legal range >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  EN_W  gate; gate = (enable == ENABLE_CODE).
- mode  in  2  0=DECODE, 1=CHASE, 2=BLINK, 3=OFF.
- switch  in  SEL_W  LED index for DECODE and BLINK.
- led  out  LED_N  active-low LED drive, registered.
- pos  out  SEL_W  current chase position register.

Behaviour:
- Reset (asynchronous):
  - led = all ones.
  - pos = 0, prescale count = 0, blink phase = 0, mode_q = 0.
- All outputs are registered; every update below occurs at a rising clk edge with rst low.
- Latency: 1 cycle from any input change to led.
- Tick generation:
  - cnt counts 0..PRESCALE-1 only when gate=1 and mode is CHASE or BLINK.
  - tick = counting && cnt == PRESCALE-1; on tick, cnt wraps to 0.
  - PRESCALE=1 gives a tick every enabled cycle.
- Gate closed (gate=0):
  - led <= all ones.
  - cnt, pos and phase hold their values; no tick.
- Mode change: mode_q registers mode. When mode != mode_q:
  - cnt <= 0, phase <= 0; pos holds.
  - led is computed for the new mode using the cleared cnt/phase; no tick that cycle.
- DECODE: led <= ~(1 << switch).
- CHASE:
  - pos_next = pos + 1 on tick, wrapping LED_N-1 -> 0; otherwise pos_next = pos.
  - pos <= pos_next; led <= ~(1 << pos_next). led and pos stay coherent.
- BLINK:
  - phase_next = ~phase on tick, else phase; phase <= phase_next.
  - led <= phase_next ? ~(1 << switch) : all ones.
  - switch change takes effect at the next edge without resetting the phase.
- OFF: led <= all ones; cnt <= 0, phase <= 0; pos holds.
- Arithmetic:
  - One-hot is LED_N bits wide; the shift is zero-extended.
  - pos wraps modulo LED_N naturally (SEL_W bits).
- Reset asserted mid-operation: immediate return to the reset values. After release, behaviour restarts from cnt=0, pos=0.
- No X on led after reset under any input combination.

Decomposition:
- Package led_pkg:
  - mode typedef enum logic [1:0] {MODE_DECODE, MODE_CHASE, MODE_BLINK, MODE_OFF}.
  - Default ENABLE_CODE constant.
  - onehot function (SEL_W -> LED_N).
- One sub-module: led_prescale_tick.
  - Parameter PRESCALE; inputs clk, rst, run, clear; output tick.
  - Instantiated once.

Test Plan (defaults SEL_W=3, PRESCALE=4):
- DECODE: mode=0, enable=4, switch=5 -> led=8'hDF after the next edge. Then enable=3 -> led=8'hFF next edge; switch sweep 0..7 -> FE, FD, FB, F7, EF, DF, BF, 7F.
- CHASE from reset: mode=1, enable=4 held.
  - Edges 1-3 -> led=FE, pos=0.
  - Edge 4 -> FD, pos=1.
  - Edge 32 -> FE, pos=0 (wrap).
- CHASE gating: drop enable to 0 for 5 cycles mid-step -> led=FF and pos frozen. On re-enable, the step completes after the remaining count (no cnt reset).
- BLINK: mode=2, switch=2, enable=4 -> edges 1-3 FF, edge 4 FB, edges 5-7 FB, edge 8 FF. Changing switch to 6 while lit -> BF next edge.
- Mode change: CHASE at pos=3 with cnt=2, switch mode to BLINK then back to CHASE. Required: cnt restarts at 0, pos stays 3, led=F7 on return, next step 4 edges later.
- Async reset: assert rst between edges during CHASE at pos=6 -> led=FF immediately (before the next edge), pos=0. Release -> resumes from FE.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED decoder/sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  localparam logic [2:0] DEF_ENABLE_CODE = 3'b100;

  // Widest LED bank the helper can address; callers truncate to their width.
  localparam int ONEHOT_MAX_SEL = 8;
  localparam int ONEHOT_MAX_N   = 1 << ONEHOT_MAX_SEL;

  // Zero-extended one-hot of an index; the caller keeps the low LED_N bits.
  function automatic logic [ONEHOT_MAX_N-1:0] onehot(input logic [ONEHOT_MAX_SEL-1:0] idx);
    logic [ONEHOT_MAX_N-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return one << idx;
  endfunction

endpackage

// File: rtl/led_decoder_seq_prescale.sv
// Step-tick prescaler: one tick every PRESCALE running cycles.
module led_prescale_tick
  import led_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(PRESCALE - 1));

  // Count while running, wrap on tick, drop to zero on clear, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_decoder_seq.sv
// Registered N-to-2^N decoder for active-low LEDs with chase and blink modes.
module led_decoder_seq
  import led_pkg::*;
#(
  parameter int               SEL_W       = 3,
  parameter int               EN_W        = 3,
  parameter logic [EN_W-1:0]  ENABLE_CODE = DEF_ENABLE_CODE,
  parameter int               PRESCALE    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [EN_W-1:0]    enable,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   switch,
  output logic [2**SEL_W-1:0] led,
  output logic [SEL_W-1:0]   pos
);

  localparam int LED_N = 2 ** SEL_W;

  typedef logic [LED_N-1:0] led_vec_t;

  mode_e      mode_in;
  mode_e      mode_q;
  logic       gate;
  logic       mode_chg;
  logic       seq_mode;
  logic       run;
  logic       clear;
  logic       tick;
  logic       phase_q;
  logic       phase_next;
  logic [SEL_W-1:0] pos_next;
  led_vec_t   led_next;

  assign mode_in  = mode_e'(mode);
  assign gate     = (enable == ENABLE_CODE);
  assign mode_chg = (mode_in != mode_q);
  assign seq_mode = (mode_in == MODE_CHASE) || (mode_in == MODE_BLINK);
  // A closed gate freezes everything; a mode change restarts the step timing.
  assign run      = gate && !mode_chg && seq_mode;
  assign clear    = gate && (mode_chg || (mode_in == MODE_OFF));

  led_prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (clear),
    .tick  (tick)
  );

  // Next LED pattern, chase position and blink phase for the current mode.
  always_comb begin
    pos_next   = pos;
    phase_next = phase_q;
    led_next   = '1;
    if (gate) begin
      if (mode_chg) begin
        phase_next = 1'b0;
      end
      case (mode_in)
        MODE_DECODE: begin
          led_next = ~led_vec_t'(onehot(ONEHOT_MAX_SEL'(switch)));
        end
        MODE_CHASE: begin
          if (tick) begin
            pos_next = pos + 1'b1;
          end
          led_next = ~led_vec_t'(onehot(ONEHOT_MAX_SEL'(pos_next)));
        end
        MODE_BLINK: begin
          if (tick) begin
            phase_next = ~phase_q;
          end
          led_next = phase_next ? ~led_vec_t'(onehot(ONEHOT_MAX_SEL'(switch))) : '1;
        end
        default: begin
          phase_next = 1'b0;
        end
      endcase
    end
  end

  // Output and state registers; LEDs go dark immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led     <= '1;
      pos     <= '0;
      phase_q <= 1'b0;
      mode_q  <= MODE_DECODE;
    end else begin
      led     <= led_next;
      pos     <= pos_next;
      phase_q <= phase_next;
      mode_q  <= mode_in;
    end
  end

endmodule

// File: tb/tb_led_decoder_seq.sv
// Self-checking bench for led_decoder_seq: directed plan plus random traffic.
module tb_led_decoder_seq;

  localparam int PRESCALE = 4;
  localparam int LED_N    = 8;

  logic       clk;
  logic       rst;
  logic [2:0] enable;
  logic [1:0] mode;
  logic [2:0] switch;
  logic [7:0] led;
  logic [2:0] pos;

  int n_assert;
  int n_fail;

  // Reference state kept as plain integers.
  int         m_cnt;
  int         m_pos;
  int         m_phase;
  int         m_modeq;
  logic [7:0] m_led;

  led_decoder_seq dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mode   (mode),
    .switch (switch),
    .led    (led),
    .pos    (pos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] lit(input int idx);
    logic [7:0] v;
    v = 8'hFF;
    v[idx % LED_N] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pos = 0; m_phase = 0; m_modeq = 0; m_led = 8'hFF;
  endtask

  // Apply one clock edge of the rules to the reference, from pre-edge inputs.
  task automatic model_edge();
    bit gate;
    bit tick;
    int md;
    md   = int'(mode);
    gate = (enable == 3'd4);
    tick = 0;
    if (!gate) begin
      m_led = 8'hFF;
    end else if (md != m_modeq) begin
      m_cnt = 0;
      m_phase = 0;
      if (md == 0)      m_led = lit(int'(switch));
      else if (md == 1) m_led = lit(m_pos);
      else              m_led = 8'hFF;
    end else if (md == 0) begin
      m_led = lit(int'(switch));
    end else if (md == 3) begin
      m_cnt = 0;
      m_phase = 0;
      m_led = 8'hFF;
    end else begin
      m_cnt = m_cnt + 1;
      if (m_cnt == PRESCALE) begin
        m_cnt = 0;
        tick = 1;
      end
      if (md == 1) begin
        if (tick) m_pos = (m_pos + 1) % LED_N;
        m_led = lit(m_pos);
      end else begin
        if (tick) m_phase = 1 - m_phase;
        m_led = (m_phase != 0) ? lit(int'(switch)) : 8'hFF;
      end
    end
    m_modeq = md;
  endtask

  task automatic check_led(input string tag, input logic [7:0] exp);
    n_assert++;
    assert (led === exp) else begin
      n_fail++;
      $error("FAIL %s: led observed %h expected %h", tag, led, exp);
    end
  endtask

  task automatic check_pos(input string tag, input logic [2:0] exp);
    n_assert++;
    assert (pos === exp) else begin
      n_fail++;
      $error("FAIL %s: pos observed %0d expected %0d", tag, pos, exp);
    end
  endtask

  // One clock edge: advance the reference, then compare both outputs after the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_led(tag, m_led);
    check_pos(tag, 3'(m_pos));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst    = 1'b1;
    enable = 3'd0;
    mode   = 2'd0;
    switch = 3'd0;
    model_reset();
    #22;
    check_led("reset_led", 8'hFF);
    check_pos("reset_pos", 3'd0);
    rst = 1'b0;

    // DECODE
    enable = 3'd4; switch = 3'd5;
    step("dec_sw5");
    check_led("dec_sw5_const", 8'hDF);
    enable = 3'd3;
    step("dec_gate_off");
    check_led("dec_gate_off_const", 8'hFF);
    enable = 3'd4;
    for (int i = 0; i < 8; i++) begin
      switch = 3'(i);
      step("dec_sweep");
      check_led("dec_sweep_const", lit(i));
    end

    // CHASE: the mode-change edge is edge 0
    mode = 2'd1;
    step("chase_enter");
    check_led("chase_enter_const", 8'hFE);
    for (int e = 1; e <= 32; e++) begin
      step("chase_run");
      if (e == 3) begin
        check_led("chase_e3", 8'hFE); check_pos("chase_e3", 3'd0);
      end
      if (e == 4) begin
        check_led("chase_e4", 8'hFD); check_pos("chase_e4", 3'd1);
      end
      if (e == 32) begin
        check_led("chase_wrap", 8'hFE); check_pos("chase_wrap", 3'd0);
      end
    end

    // CHASE gating mid-step: two counts consumed, five cycles closed
    step("gate_pre");
    step("gate_pre");
    enable = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step("gate_closed");
      check_led("gate_closed_const", 8'hFF);
      check_pos("gate_closed_const", 3'd0);
    end
    enable = 3'd4;
    step("gate_resume1");
    check_led("gate_resume1_const", 8'hFE);
    step("gate_resume2");
    check_led("gate_resume2_const", 8'hFD);
    check_pos("gate_resume2_const", 3'd1);

    // Mode change round trip at pos=3, cnt=2
    for (int i = 0; i < 100 && !(m_pos == 3 && m_cnt == 2); i++) step("mc_seek");
    n_assert++;
    assert (m_pos == 3 && m_cnt == 2) else begin
      n_fail++;
      $error("FAIL mc_seek: pos %0d cnt %0d not reached", m_pos, m_cnt);
    end
    mode = 2'd2;
    step("mc_to_blink");
    mode = 2'd1;
    step("mc_back");
    check_led("mc_back_const", 8'hF7);
    check_pos("mc_back_const", 3'd3);
    for (int e = 1; e <= 4; e++) step("mc_after");
    check_led("mc_step_const", 8'hEF);
    check_pos("mc_step_const", 3'd4);

    // BLINK
    mode = 2'd2; switch = 3'd2;
    step("blink_enter");
    for (int e = 1; e <= 12; e++) begin
      step("blink_run");
      if (e == 3) check_led("blink_e3", 8'hFF);
      if (e == 4) check_led("blink_e4", 8'hFB);
      if (e == 7) check_led("blink_e7", 8'hFB);
      if (e == 8) check_led("blink_e8", 8'hFF);
    end
    switch = 3'd6;
    step("blink_sw6");
    check_led("blink_sw6_const", 8'hBF);

    // Async reset during CHASE at pos=6
    mode = 2'd1;
    step("ar_enter");
    for (int i = 0; i < 100 && m_pos != 6; i++) step("ar_seek");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_led("ar_immediate", 8'hFF);
    check_pos("ar_immediate", 3'd0);
    #3;
    rst = 1'b0;
    step("ar_resume");
    check_led("ar_resume_const", 8'hFE);

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) enable = 3'($urandom_range(0, 7));
      else enable = 3'd4;
      if ($urandom_range(0, 3) == 0) switch = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 60) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_led("rand_reset", 8'hFF);
        check_pos("rand_reset", 3'd0);
        #2;
        rst = 1'b0;
      end
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
